// File: rtl/data_mem_responder_if.sv
// Load/store port between the core's memory stage and the data-memory responder.
// The core side drives requests and accepts responses; the responder side answers them.
interface data_mem_responder_if;
    logic        req_valid;
    logic        req_ready;
    logic        req_write;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic [1:0]  req_size;
    logic        req_unsigned;
    logic        rsp_valid;
    logic        rsp_ready;
    logic [31:0] rsp_rdata;
    logic        rsp_error;

    modport master (
        output req_valid, req_write, req_addr, req_wdata, req_size, req_unsigned, rsp_ready,
        input  req_ready, rsp_valid, rsp_rdata, rsp_error
    );

    modport slave (
        input  req_valid, req_write, req_addr, req_wdata, req_size, req_unsigned, rsp_ready,
        output req_ready, rsp_valid, rsp_rdata, rsp_error
    );
endinterface

// File: rtl/data_mem_responder.sv
// Data-memory responder: accepts one load/store at a time, waits WAIT_CYCLES, then
// performs a byte/half/word access on a little-endian word RAM and holds the
// response (sign/zero-extended load data or an error flag) until the core takes it.
module data_mem_responder #(
    parameter int DEPTH_WORDS = 1024,
    parameter int WAIT_CYCLES = 1
) (
    input logic                 clk,
    input logic                 reset,
    data_mem_responder_if.slave bus
);
    localparam int IDX_W = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;

    typedef enum logic [1:0] {
        IDLE,
        WAIT,
        RESP
    } state_t;

    state_t      state_q, state_d;
    logic [3:0]  cnt_q, cnt_d;
    logic        reqWrite_q, reqWrite_d;
    logic [31:0] reqAddr_q, reqAddr_d;
    logic [31:0] reqWdata_q, reqWdata_d;
    logic [1:0]  reqSize_q, reqSize_d;
    logic        reqUnsigned_q, reqUnsigned_d;
    logic [31:0] rdata_q, rdata_d;
    logic        error_q, error_d;

    logic [31:0] mem [DEPTH_WORDS];

    logic             accessNow;
    logic             accessErr;
    logic             sizeIllegal;
    logic             halfMisaligned;
    logic             wordMisaligned;
    logic             outOfRange;
    logic [IDX_W-1:0] wordIdx;
    logic [31:0]      readWord;
    logic [7:0]       loadByte;
    logic [15:0]      loadHalf;
    logic [31:0]      loadData;
    logic [3:0]       byteEn;
    logic [31:0]      laneData;
    logic             memWe;

    // The access happens on the edge where the wait counter has run out; the
    // out-of-range test compares the whole word index so high addresses never alias.
    assign accessNow      = (state_q == WAIT) && (cnt_q == 4'd0);
    assign sizeIllegal    = (reqSize_q == 2'b11);
    assign halfMisaligned = (reqSize_q == 2'b01) && reqAddr_q[0];
    assign wordMisaligned = (reqSize_q == 2'b10) && (reqAddr_q[1:0] != 2'b00);
    assign outOfRange     = ({2'b00, reqAddr_q[31:2]} >= 32'(DEPTH_WORDS));
    assign accessErr      = sizeIllegal || halfMisaligned || wordMisaligned || outOfRange;
    assign wordIdx        = reqAddr_q[IDX_W+1:2];
    assign readWord       = mem[wordIdx];
    assign memWe          = accessNow && reqWrite_q && !accessErr;

    assign bus.req_ready = (state_q == IDLE);
    assign bus.rsp_valid = (state_q == RESP);
    assign bus.rsp_rdata = rdata_q;
    assign bus.rsp_error = error_q;

    // Pick the addressed byte or halfword out of the stored word and extend it.
    always_comb begin
        loadByte = readWord[{reqAddr_q[1:0], 3'b000} +: 8];
        loadHalf = reqAddr_q[1] ? readWord[31:16] : readWord[15:0];
        case (reqSize_q)
            2'b00:   loadData = {{24{~reqUnsigned_q & loadByte[7]}}, loadByte};
            2'b01:   loadData = {{16{~reqUnsigned_q & loadHalf[15]}}, loadHalf};
            default: loadData = readWord;
        endcase
    end

    // Replicate store data into every lane and enable only the lanes being written.
    always_comb begin
        byteEn   = 4'b0000;
        laneData = reqWdata_q;
        case (reqSize_q)
            2'b00: begin
                byteEn   = 4'b0001 << reqAddr_q[1:0];
                laneData = {4{reqWdata_q[7:0]}};
            end
            2'b01: begin
                byteEn   = reqAddr_q[1] ? 4'b1100 : 4'b0011;
                laneData = {2{reqWdata_q[15:0]}};
            end
            2'b10: begin
                byteEn   = 4'b1111;
                laneData = reqWdata_q;
            end
            default: begin
                byteEn   = 4'b0000;
                laneData = reqWdata_q;
            end
        endcase
    end

    // Next-state logic: latch the request in IDLE, count down wait states, then
    // register the response and hold it until the core accepts it.
    always_comb begin
        state_d       = state_q;
        cnt_d         = cnt_q;
        reqWrite_d    = reqWrite_q;
        reqAddr_d     = reqAddr_q;
        reqWdata_d    = reqWdata_q;
        reqSize_d     = reqSize_q;
        reqUnsigned_d = reqUnsigned_q;
        rdata_d       = rdata_q;
        error_d       = error_q;
        case (state_q)
            IDLE: begin
                if (bus.req_valid) begin
                    reqWrite_d    = bus.req_write;
                    reqAddr_d     = bus.req_addr;
                    reqWdata_d    = bus.req_wdata;
                    reqSize_d     = bus.req_size;
                    reqUnsigned_d = bus.req_unsigned;
                    cnt_d         = 4'(WAIT_CYCLES);
                    state_d       = WAIT;
                end
            end
            WAIT: begin
                if (cnt_q != 4'd0) begin
                    cnt_d = cnt_q - 4'd1;
                end else begin
                    error_d = accessErr;
                    rdata_d = (accessErr || reqWrite_q) ? 32'd0 : loadData;
                    state_d = RESP;
                end
            end
            RESP: begin
                if (bus.rsp_ready) begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State and response registers; reset abandons any transaction in flight.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q       <= IDLE;
            cnt_q         <= 4'd0;
            reqWrite_q    <= 1'b0;
            reqAddr_q     <= 32'd0;
            reqWdata_q    <= 32'd0;
            reqSize_q     <= 2'b00;
            reqUnsigned_q <= 1'b0;
            rdata_q       <= 32'd0;
            error_q       <= 1'b0;
        end else begin
            state_q       <= state_d;
            cnt_q         <= cnt_d;
            reqWrite_q    <= reqWrite_d;
            reqAddr_q     <= reqAddr_d;
            reqWdata_q    <= reqWdata_d;
            reqSize_q     <= reqSize_d;
            reqUnsigned_q <= reqUnsigned_d;
            rdata_q       <= rdata_d;
            error_q       <= error_d;
        end
    end

    // RAM lane writes; contents deliberately survive reset.
    always_ff @(posedge clk) begin
        for (int lane = 0; lane < 4; lane++) begin
            if (memWe && byteEn[lane]) begin
                mem[wordIdx][8*lane +: 8] <= laneData[8*lane +: 8];
            end
        end
    end
endmodule

// File: tb/tb_data_mem_responder.sv
// Self-checking bench: three responders (1, 0 and 4 wait states) driven by directed
// and random load/store traffic, compared against a byte-addressed reference memory.
module tb_data_mem_responder;
    localparam int DEPTH = 64;
    localparam logic [11:0] WAITS = {4'd4, 4'd0, 4'd1};

    logic        clk;
    logic        resetSig    [3];
    logic        reqValid    [3];
    logic        reqWrite    [3];
    logic [31:0] reqAddr     [3];
    logic [31:0] reqWdata    [3];
    logic [1:0]  reqSize     [3];
    logic        reqUnsigned [3];
    logic        rspReady    [3];
    logic        reqReady    [3];
    logic        rspValid    [3];
    logic [31:0] rspRdata    [3];
    logic        rspError    [3];

    logic [7:0] modelMem [3][4*DEPTH];

    int checks = 0;
    int errors = 0;

    for (genvar g = 0; g < 3; g++) begin : gInst
        data_mem_responder_if bus ();
        assign bus.req_valid    = reqValid[g];
        assign bus.req_write    = reqWrite[g];
        assign bus.req_addr     = reqAddr[g];
        assign bus.req_wdata    = reqWdata[g];
        assign bus.req_size     = reqSize[g];
        assign bus.req_unsigned = reqUnsigned[g];
        assign bus.rsp_ready    = rspReady[g];
        assign reqReady[g]      = bus.req_ready;
        assign rspValid[g]      = bus.rsp_valid;
        assign rspRdata[g]      = bus.rsp_rdata;
        assign rspError[g]      = bus.rsp_error;

        data_mem_responder #(
            .DEPTH_WORDS(DEPTH),
            .WAIT_CYCLES(int'(WAITS[4*g +: 4]))
        ) dut (
            .clk  (clk),
            .reset(resetSig[g]),
            .bus  (bus)
        );
    end

    // Free-running 10 ns clock.
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Hard stop in case something wedges beyond every bounded wait.
    initial begin
        #1000000;
        $display("[TB] FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "[TB] watchdog");
    end

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        checks++;
        if (observed !== expected) begin
            errors++;
            $display("[TB] FAIL %s: observed 0x%08h expected 0x%08h", tag, observed, expected);
        end
    endtask

    function automatic bit expErr(input logic [31:0] a, input logic [1:0] s);
        if (s == 2'b11) return 1'b1;
        if (s == 2'b01 && (a % 2) != 0) return 1'b1;
        if (s == 2'b10 && (a % 4) != 0) return 1'b1;
        if ((a / 4) >= 32'(DEPTH)) return 1'b1;
        return 1'b0;
    endfunction

    function automatic logic [31:0] modelLoad(input int k, input logic [31:0] a, input logic [1:0] s, input bit uns);
        int n;
        logic [31:0] v;
        n = 1 << s;
        v = 32'd0;
        for (int i = 0; i < n; i++) v = v | (32'(modelMem[k][int'(a) + i]) << (8 * i));
        if (!uns && n < 4 && v[8*n-1]) v = v | ~((32'd1 << (8 * n)) - 32'd1);
        return v;
    endfunction

    // One full transaction with optional response backpressure, checked against the model.
    task automatic applyStimulus(input int k, input bit wr, input logic [31:0] addr, input logic [31:0] wdata,
                                 input logic [1:0] size, input bit uns, input int hold, input string tag,
                                 output logic [31:0] obs);
        logic [31:0] expData;
        bit          expE;
        int          lat;
        int          guard;
        expE    = expErr(addr, size);
        expData = (expE || wr) ? 32'd0 : modelLoad(k, addr, size, uns);
        @(negedge clk);
        guard = 0;
        while (!reqReady[k] && guard < 50) begin
            @(negedge clk);
            guard++;
        end
        checkOutput({tag, ".readyIdle"}, 32'(reqReady[k]), 32'd1);
        reqValid[k]    = 1'b1;
        reqWrite[k]    = wr;
        reqAddr[k]     = addr;
        reqWdata[k]    = wdata;
        reqSize[k]     = size;
        reqUnsigned[k] = uns;
        @(posedge clk);
        #1;
        reqWrite[k]    = ~wr;
        reqAddr[k]     = $urandom;
        reqWdata[k]    = $urandom;
        reqSize[k]     = 2'($urandom_range(0, 3));
        reqUnsigned[k] = ~uns;
        lat = 0;
        do begin
            @(posedge clk);
            #1;
            lat++;
        end while (!rspValid[k] && lat < 64);
        checkOutput({tag, ".latency"}, 32'(lat), 32'(int'(WAITS[4*k +: 4]) + 1));
        checkOutput({tag, ".rdata"}, rspRdata[k], expData);
        checkOutput({tag, ".error"}, 32'(rspError[k]), 32'(expE));
        obs = rspRdata[k];
        for (int h = 0; h < hold; h++) begin
            @(posedge clk);
            #1;
            checkOutput({tag, ".holdValid"}, 32'(rspValid[k]), 32'd1);
            checkOutput({tag, ".holdRdata"}, rspRdata[k], expData);
            checkOutput({tag, ".holdReqReady"}, 32'(reqReady[k]), 32'd0);
        end
        rspReady[k] = 1'b1;
        @(posedge clk);
        #1;
        rspReady[k] = 1'b0;
        reqValid[k] = 1'b0;
        checkOutput({tag, ".idleAfterRsp"}, 32'(reqReady[k]), 32'd1);
        checkOutput({tag, ".rspValidLow"}, 32'(rspValid[k]), 32'd0);
        if (wr && !expE) begin
            for (int i = 0; i < (1 << size); i++) modelMem[k][int'(addr) + i] = 8'(wdata >> (8 * i));
        end
    endtask

    // Test sequence: reset, directed cases, throughput, mid-transaction reset, random traffic.
    initial begin
        logic [31:0] obs;
        logic [31:0] a;
        int          r;
        int          nAcc;
        int          prevAcc;

        for (int k = 0; k < 3; k++) begin
            resetSig[k]    = 1'b1;
            reqValid[k]    = 1'b0;
            reqWrite[k]    = 1'b0;
            reqAddr[k]     = 32'd0;
            reqWdata[k]    = 32'd0;
            reqSize[k]     = 2'b00;
            reqUnsigned[k] = 1'b0;
            rspReady[k]    = 1'b0;
        end
        repeat (3) @(negedge clk);
        for (int k = 0; k < 3; k++) begin
            checkOutput("reset.reqReady", 32'(reqReady[k]), 32'd1);
            checkOutput("reset.rspValid", 32'(rspValid[k]), 32'd0);
            checkOutput("reset.rdata", rspRdata[k], 32'd0);
            checkOutput("reset.error", 32'(rspError[k]), 32'd0);
            resetSig[k] = 1'b0;
        end

        $display("[TB] directed word/byte/half accesses");
        applyStimulus(0, 1'b1, 32'h10, 32'hDEADBEEF, 2'b10, 1'b0, 0, "SW10", obs);
        applyStimulus(0, 1'b0, 32'h10, 32'h0, 2'b10, 1'b0, 0, "LW10", obs);
        checkOutput("LW10.const", obs, 32'hDEADBEEF);
        applyStimulus(0, 1'b0, 32'h13, 32'h0, 2'b00, 1'b0, 0, "LB13", obs);
        checkOutput("LB13.const", obs, 32'hFFFFFFDE);
        applyStimulus(0, 1'b0, 32'h13, 32'h0, 2'b00, 1'b1, 0, "LBU13", obs);
        checkOutput("LBU13.const", obs, 32'h000000DE);
        applyStimulus(0, 1'b0, 32'h12, 32'h0, 2'b01, 1'b0, 0, "LH12", obs);
        checkOutput("LH12.const", obs, 32'hFFFFDEAD);
        applyStimulus(0, 1'b0, 32'h10, 32'h0, 2'b01, 1'b1, 0, "LHU10", obs);
        checkOutput("LHU10.const", obs, 32'h0000BEEF);
        applyStimulus(0, 1'b1, 32'h11, 32'h00000055, 2'b00, 1'b0, 0, "SB11", obs);
        applyStimulus(0, 1'b0, 32'h10, 32'h0, 2'b10, 1'b0, 0, "LW10b", obs);
        checkOutput("LW10b.const", obs, 32'hDEAD55EF);

        $display("[TB] directed error cases");
        applyStimulus(0, 1'b0, 32'h01, 32'h0, 2'b01, 1'b0, 0, "LHmis", obs);
        applyStimulus(0, 1'b0, 32'h02, 32'h0, 2'b10, 1'b0, 0, "LWmis", obs);
        applyStimulus(0, 1'b0, 32'h10, 32'h0, 2'b11, 1'b0, 0, "LSize3", obs);
        applyStimulus(0, 1'b0, 32'(4 * DEPTH), 32'h0, 2'b10, 1'b0, 0, "LWrange", obs);
        applyStimulus(0, 1'b1, 32'h11, 32'h0000FFFF, 2'b01, 1'b0, 0, "SHmis", obs);
        applyStimulus(0, 1'b0, 32'h10, 32'h0, 2'b10, 1'b0, 5, "LWhold", obs);
        checkOutput("LWhold.const", obs, 32'hDEAD55EF);

        $display("[TB] continuous traffic with zero wait states");
        @(negedge clk);
        reqValid[1]    = 1'b1;
        reqWrite[1]    = 1'b0;
        reqAddr[1]     = 32'h0;
        reqSize[1]     = 2'b10;
        reqUnsigned[1] = 1'b0;
        rspReady[1]    = 1'b1;
        nAcc    = 0;
        prevAcc = -1;
        for (int c = 0; c < 13; c++) begin
            if (reqReady[1]) begin
                if (prevAcc >= 0) checkOutput("b2b.period", 32'(c - prevAcc), 32'd3);
                prevAcc = c;
                nAcc++;
            end
            @(negedge clk);
        end
        checkOutput("b2b.count", 32'(nAcc), 32'd5);
        reqValid[1] = 1'b0;
        repeat (3) @(negedge clk);
        rspReady[1] = 1'b0;

        $display("[TB] reset during a pending store");
        applyStimulus(2, 1'b1, 32'h20, 32'hAAAAAAAA, 2'b10, 1'b0, 0, "preSW20", obs);
        applyStimulus(2, 1'b0, 32'h20, 32'h0, 2'b10, 1'b0, 0, "preLW20", obs);
        @(negedge clk);
        reqValid[2]    = 1'b1;
        reqWrite[2]    = 1'b1;
        reqAddr[2]     = 32'h20;
        reqWdata[2]    = 32'h12345678;
        reqSize[2]     = 2'b10;
        reqUnsigned[2] = 1'b0;
        @(posedge clk);
        #1;
        reqValid[2] = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        resetSig[2] = 1'b1;
        #1;
        checkOutput("midRst.reqReady", 32'(reqReady[2]), 32'd1);
        checkOutput("midRst.rspValid", 32'(rspValid[2]), 32'd0);
        checkOutput("midRst.rdata", rspRdata[2], 32'd0);
        checkOutput("midRst.error", 32'(rspError[2]), 32'd0);
        repeat (6) @(negedge clk);
        resetSig[2] = 1'b0;
        applyStimulus(2, 1'b0, 32'h20, 32'h0, 2'b10, 1'b0, 0, "postRstLW20", obs);
        checkOutput("postRstLW20.const", obs, 32'hAAAAAAAA);

        $display("[TB] random traffic");
        for (int k = 0; k < 3; k++) begin
            for (int w = 0; w < 16; w++) begin
                applyStimulus(k, 1'b1, 32'(4 * w), $urandom, 2'b10, 1'b0, 0, "fill", obs);
            end
            for (int n = 0; n < 40; n++) begin
                r = $urandom_range(0, 9);
                if (r == 0) a = 32'(4 * DEPTH) + 32'($urandom_range(0, 63));
                else if (r == 1) a = $urandom | 32'h8000_0000;
                else a = 32'($urandom_range(0, 63));
                applyStimulus(k, $urandom_range(0, 1) == 1, a, $urandom, 2'($urandom_range(0, 3)),
                              $urandom_range(0, 1) == 1, $urandom_range(0, 2), "rand", obs);
            end
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/data_mem_responder.md
# data_mem_responder

Data-memory responder for the RISC-V core's load/store port. It accepts one request at a time over a valid/ready handshake and performs byte, halfword or word reads and writes into an internal word-organised RAM. Loads are returned sign- or zero-extended after a programmable number of wait states, and misaligned or out-of-range accesses are flagged. It sits between the core's memory-stage address/store-data outputs and its load-data input, and gives the core a realistic, stallable memory.

## Interface
- DEPTH_WORDS, 1024: number of 32-bit words in the RAM; legal word index 0..DEPTH_WORDS-1.
- WAIT_CYCLES, 1: extra wait states before each access (0..15).

- clk  in  1  single clock, rising edge.
- reset  in  1  asynchronous, active-high reset.
- req_valid  in  1  request present.
- req_ready  out  1  responder can accept; high only in IDLE.
- req_write  in  1  1 = store, 0 = load.
- req_addr  in  32  byte address.
- req_wdata  in  32  store data, low-aligned (byte in [7:0], half in [15:0]).
- req_size  in  2  00 byte, 01 half, 10 word, 11 illegal.
- req_unsigned  in  1  load zero-extends when 1 (LBU/LHU); ignored for word and for stores.
- rsp_valid  out  1  response present.
- rsp_ready  in  1  core accepts the response.
- rsp_rdata  out  32  load data; 0 for stores and errors.
- rsp_error  out  1  misaligned, illegal-size or out-of-range access.

## Operation
- FSM states: IDLE, WAIT, RESP. Reset state is IDLE.
- IDLE: req_ready=1. When req_valid=1 at a clock edge, latch all req_* fields, load cnt=WAIT_CYCLES and go to WAIT.
- WAIT: if cnt!=0, decrement cnt. If cnt==0, perform the access, register rsp_rdata and rsp_error, and go to RESP.
- RESP: rsp_valid=1. rsp_rdata and rsp_error are held stable. When rsp_ready=1 at a clock edge, go to IDLE and clear rsp_valid.
- Error check, applied at the access edge:
  - req_size=11;
  - half with addr[0]=1;
  - word with addr[1:0]!=0;
  - addr[31:2] >= DEPTH_WORDS (full 30-bit compare, no wrap).
- On error: no RAM write, rsp_rdata=0, rsp_error=1.
- Store:
  - Byte writes wdata[7:0] to lane addr[1:0].
  - Half writes wdata[15:0] to lanes {addr[1],0}/{addr[1],1}.
  - Word writes all four lanes.
  - Unselected lanes are unchanged. rsp_rdata=0.
- Load:
  - Byte selects lane addr[1:0] and half selects halfword addr[1].
  - Sign-extend from bit 7/15, or zero-extend if req_unsigned=1.
- Byte order is little-endian: lane 0 = bits [7:0].
- The RAM is not cleared by reset. Contents are undefined until written.

## Timing
- Reset values: req_ready=1 (state IDLE), rsp_valid=0, rsp_rdata=0, rsp_error=0, cnt=0.
- Accept edge E0 → rsp_valid visible after edge E0+WAIT_CYCLES+1. With WAIT_CYCLES=0 the response appears the cycle after acceptance.
- The store takes effect at the access edge E0+WAIT_CYCLES+1. A load issued after that response observes the new data.
- Response-handshake edge → IDLE. req_ready is high in the following cycle; there is no same-cycle turnaround. Back-to-back period is WAIT_CYCLES+3 cycles with rsp_ready held at 1.
- Request inputs are ignored outside IDLE. req_valid may stay high without causing a second acceptance.
- rsp_ready held low keeps RESP indefinitely, with outputs frozen.
- Reset asserted mid-transaction (WAIT or RESP) aborts immediately to IDLE with outputs at reset values. A store whose access edge has not occurred is not written. A completed store remains in the RAM.

## Test plan
- Word store/load, WAIT_CYCLES=1: store 0xDEADBEEF to 0x10, then load word 0x10 → rsp_rdata=0xDEADBEEF, rsp_error=0. rsp_valid rises 2 cycles after each accept.
- Byte/half extension: after the word above, the following loads return:
  - LB 0x13 → 0xFFFFFFDE
  - LBU 0x13 → 0x000000DE
  - LH 0x12 → 0xFFFFDEAD
  - LHU 0x10 → 0x0000BEEF
- Partial store: store byte 0x55 to 0x11 over 0xDEADBEEF, then load word 0x10 → 0xDEAD55EF.
- Errors:
  - half at 0x01 → error=1, rdata=0;
  - word at 0x02 → error=1;
  - size=11 → error=1;
  - word at 4*DEPTH_WORDS → error=1;
  - a faulting store at 0x11 leaves the word at 0x10 unchanged.
- Backpressure/handshake: hold rsp_ready=0 for 5 cycles → rsp_valid and rsp_rdata stable and req_ready=0 throughout. Release → IDLE next cycle. With WAIT_CYCLES=0 and continuous traffic, the accept period is 3 cycles.
- Reset mid-operation: with WAIT_CYCLES=4, assert reset 2 cycles after accepting a store of 0x12345678 to 0x20 → outputs return to reset values immediately. A subsequent load of 0x20 does not return 0x12345678 (pre-fill 0x20 with 0xAAAAAAAA → reads 0xAAAAAAAA).
